// File: rtl/vec_acc_rob.sv
// In-order reorder buffer between the scalar core and vector dispatch: allocates IDs,
// registers dispatch, collects out-of-order completions. Define VEC_ROB_BYPASS_EN for head bypass.
module vec_acc_rob #(
  parameter  int INSTR_BITS    = 32,
  parameter  int XLEN          = 32,
  parameter  int DEPTH         = 8,
  localparam int TRANS_ID_BITS = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  // scalar request
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [INSTR_BITS-1:0]    req_instr_i,
  input  logic [XLEN-1:0]          req_rs1_i,
  input  logic [XLEN-1:0]          req_rs2_i,
  // dispatch
  output logic                     disp_valid_o,
  input  logic                     disp_ready_i,
  output logic [INSTR_BITS-1:0]    disp_instr_o,
  output logic [XLEN-1:0]          disp_rs1_o,
  output logic [XLEN-1:0]          disp_rs2_o,
  output logic [TRANS_ID_BITS-1:0] disp_id_o,
  // unit completion
  input  logic                     cpl_valid_i,
  input  logic [TRANS_ID_BITS-1:0] cpl_id_i,
  input  logic                     cpl_err_i,
  input  logic [XLEN-1:0]          cpl_res_i,
  // in-order response
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic                     resp_err_o,
  output logic [XLEN-1:0]          resp_res_o,
  output logic [TRANS_ID_BITS-1:0] resp_id_o,
  // status
  output logic [TRANS_ID_BITS:0]   outstanding_o,
  output logic                     proto_err_o
);

  typedef enum logic [1:0] {
    E_FREE   = 2'd0,
    E_ISSUED = 2'd1,
    E_DONE   = 2'd2
  } entry_state_e;

  localparam logic [TRANS_ID_BITS:0] DEPTH_CNT = (TRANS_ID_BITS+1)'(DEPTH);
  localparam logic [TRANS_ID_BITS-1:0] ID_ONE  = TRANS_ID_BITS'(1);

  entry_state_e             state_q [DEPTH];
  entry_state_e             state_d [DEPTH];
  logic                     err_q   [DEPTH];
  logic [XLEN-1:0]          res_q   [DEPTH];

  logic [TRANS_ID_BITS-1:0] head_q, head_d;
  logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
  logic [TRANS_ID_BITS:0]   count_q, count_d;
  logic                     proto_err_q, proto_err_d;

  logic                     disp_valid_q, disp_valid_d;
  logic [INSTR_BITS-1:0]    disp_instr_q, disp_instr_d;
  logic [XLEN-1:0]          disp_rs1_q, disp_rs1_d;
  logic [XLEN-1:0]          disp_rs2_q, disp_rs2_d;
  logic [TRANS_ID_BITS-1:0] disp_id_q, disp_id_d;

  logic accept;
  logic retire;
  logic cpl_legal;
  logic head_done;

  // Ready depends only on registered state and the downstream ready, never on req_valid_i.
  assign req_ready_o = (count_q < DEPTH_CNT) & (~disp_valid_q | disp_ready_i);
  assign accept      = req_valid_i & req_ready_o;
  assign cpl_legal   = cpl_valid_i & (state_q[cpl_id_i] == E_ISSUED);
  assign head_done   = (state_q[head_q] == E_DONE);

`ifdef VEC_ROB_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit   = cpl_legal & (cpl_id_i == head_q);
  assign resp_valid_o = head_done | bypass_hit;
  always_comb begin
    resp_err_o = 1'b0;
    resp_res_o = '0;
    if (bypass_hit) begin
      resp_err_o = cpl_err_i;
      resp_res_o = cpl_res_i;
    end else if (head_done) begin
      resp_err_o = err_q[head_q];
      resp_res_o = res_q[head_q];
    end
  end
`else
  assign resp_valid_o = head_done;
  assign resp_err_o   = head_done & err_q[head_q];
  assign resp_res_o   = head_done ? res_q[head_q] : '0;
`endif

  assign resp_id_o     = head_q;
  assign retire        = resp_valid_o & resp_ready_i;
  assign outstanding_o = count_q;
  assign proto_err_o   = proto_err_q;

  assign disp_valid_o  = disp_valid_q;
  assign disp_instr_o  = disp_instr_q;
  assign disp_rs1_o    = disp_rs1_q;
  assign disp_rs2_o    = disp_rs2_q;
  assign disp_id_o     = disp_id_q;

  // Entry lifecycle. The retire write follows the completion write so a bypassed head
  // goes straight from ISSUED to FREE.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    for (int i = 0; i < DEPTH; i++) state_d[i] = state_q[i];
    head_d      = head_q;
    tail_d      = tail_q;
    proto_err_d = proto_err_q | (cpl_valid_i & ~cpl_legal);

    if (cpl_legal) state_d[cpl_id_i] = E_DONE;
    if (retire) begin
      state_d[head_q] = E_FREE;
      head_d          = head_q + ID_ONE;
    end
    if (accept) begin
      state_d[tail_q] = E_ISSUED;
      tail_d          = tail_q + ID_ONE;
    end

    unique case ({accept, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Dispatch register: hold while stalled, clear on handshake, reload on back-to-back accept.
  always_comb begin
    disp_valid_d = disp_valid_q;
    disp_instr_d = disp_instr_q;
    disp_rs1_d   = disp_rs1_q;
    disp_rs2_d   = disp_rs2_q;
    disp_id_d    = disp_id_q;
    if (accept) begin
      disp_valid_d = 1'b1;
      disp_instr_d = req_instr_i;
      disp_rs1_d   = req_rs1_i;
      disp_rs2_d   = req_rs2_i;
      disp_id_d    = tail_q;
    end else if (disp_valid_q & disp_ready_i) begin
      disp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < DEPTH; i++) state_q[i] <= E_FREE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      proto_err_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_instr_q <= '0;
      disp_rs1_q   <= '0;
      disp_rs2_q   <= '0;
      disp_id_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      proto_err_q  <= proto_err_d;
      disp_valid_q <= disp_valid_d;
      disp_instr_q <= disp_instr_d;
      disp_rs1_q   <= disp_rs1_d;
      disp_rs2_q   <= disp_rs2_d;
      disp_id_q    <= disp_id_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; it is only observed when the entry is DONE,
  // and the response outputs are forced to zero otherwise.
  always_ff @(posedge clk_i) begin
    if (cpl_legal) begin
      err_q[cpl_id_i] <= cpl_err_i;
      res_q[cpl_id_i] <= cpl_res_i;
    end
  end

endmodule
